// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, ALU operation codes,
// operand-A select values and the decoded-slot record.
package decode_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b001000;
  localparam logic [5:0] ALU_SLL  = 6'b000001;
  localparam logic [5:0] ALU_SLT  = 6'b000010;
  localparam logic [5:0] ALU_SLTU = 6'b000011;
  localparam logic [5:0] ALU_XOR  = 6'b000100;
  localparam logic [5:0] ALU_SRL  = 6'b000101;
  localparam logic [5:0] ALU_SRA  = 6'b001101;
  localparam logic [5:0] ALU_OR   = 6'b000110;
  localparam logic [5:0] ALU_AND  = 6'b000111;
  localparam logic [5:0] ALU_BEQ  = 6'b010000;
  localparam logic [5:0] ALU_BNE  = 6'b010001;
  localparam logic [5:0] ALU_BLT  = 6'b010100;
  localparam logic [5:0] ALU_BGE  = 6'b010101;
  localparam logic [5:0] ALU_BLTU = 6'b010110;
  localparam logic [5:0] ALU_BGEU = 6'b010111;
  localparam logic [5:0] ALU_JAL  = 6'b011111;
  localparam logic [5:0] ALU_JALR = 6'b111111;

  localparam logic [1:0] OPA_RS1 = 2'b00;
  localparam logic [1:0] OPA_PC  = 2'b01;
  localparam logic [1:0] OPA_PC4 = 2'b10;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [4:0]  write_sel;
    logic        wen;
    logic        branch_op;
    logic        next_pc_select;
    logic [31:0] imm32;
    logic [1:0]  op_a_sel;
    logic        op_b_sel;
    logic [5:0]  alu_control;
    logic        mem_wen;
    logic        wb_sel;
    logic        illegal;
  } decode_t;

  // Instruction classes that read rs1 / rs2 (drives load-use detection).
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return (opcode == R_TYPE) || (opcode == I_TYPE) || (opcode == LOAD) ||
           (opcode == STORE) || (opcode == BRANCH) || (opcode == JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == R_TYPE) || (opcode == STORE) || (opcode == BRANCH);
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I decoder: instruction word -> control fields,
// sign-extended immediate and illegal flag.
module decode_comb
  import decode_pkg::*;
#(
  parameter bit ZERO_REG_WEN = 1'b1
) (
  input  logic [31:0] instruction,
  output decode_t     dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};

  // Per-opcode field decode, then illegal and x0 write-enable suppression.
  always_comb begin
    dec           = '0;
    dec.write_sel = instruction[11:7];
    unique case (opcode)
      R_TYPE: begin
        dec.wen         = 1'b1;
        dec.alu_control = {2'b00, funct7 == FUNCT7_ALT, funct3};
        dec.illegal     = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
      end
      I_TYPE: begin
        dec.wen         = 1'b1;
        dec.op_b_sel    = 1'b1;
        dec.imm32       = imm_i;
        // Only srai uses the alternate funct7; for other ops those bits are immediate.
        dec.alu_control = {2'b00, (funct3 == 3'b101) && (funct7 == FUNCT7_ALT), funct3};
        dec.illegal     = ((funct3 == 3'b001) && (funct7 != FUNCT7_BASE)) ||
                          ((funct3 == 3'b101) && (funct7 != FUNCT7_BASE) &&
                           (funct7 != FUNCT7_ALT));
      end
      LOAD: begin
        dec.wen      = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.wb_sel   = 1'b1;
        dec.imm32    = imm_i;
      end
      STORE: begin
        dec.mem_wen  = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.imm32    = imm_s;
      end
      BRANCH: begin
        dec.branch_op      = 1'b1;
        dec.next_pc_select = 1'b1;
        dec.imm32          = imm_b;
        dec.alu_control    = {3'b010, funct3};
        dec.illegal        = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      JAL: begin
        dec.wen            = 1'b1;
        dec.next_pc_select = 1'b1;
        dec.op_a_sel       = OPA_PC4;
        dec.imm32          = imm_j;
        dec.alu_control    = ALU_JAL;
      end
      JALR: begin
        dec.wen            = 1'b1;
        dec.next_pc_select = 1'b1;
        dec.op_a_sel       = OPA_PC4;
        dec.imm32          = imm_i;
        dec.alu_control    = ALU_JALR;
      end
      AUIPC: begin
        dec.wen      = 1'b1;
        dec.op_a_sel = OPA_PC;
        dec.op_b_sel = 1'b1;
        dec.imm32    = imm_u;
      end
      LUI: begin
        // Executed as x0 + imm; execute ignores the rs1 read.
        dec.wen      = 1'b1;
        dec.op_a_sel = OPA_RS1;
        dec.op_b_sel = 1'b1;
        dec.imm32    = imm_u;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Trapping instructions must not update architectural state.
    if (dec.illegal) begin
      dec.wen     = 1'b0;
      dec.mem_wen = 1'b0;
    end
    if (ZERO_REG_WEN && (dec.write_sel == 5'd0)) dec.wen = 1'b0;
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// Registered, valid/ready handshaked RV32I decode stage with one output slot,
// load-use bubble insertion, flush and illegal-instruction flagging.
module decode_stage_pipelined
  import decode_pkg::*;
#(
  parameter int ADDRESS_BITS  = 16,
  parameter bit HAZARD_DETECT = 1'b1,
  parameter bit ZERO_REG_WEN  = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [31:0]             instruction,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4:0]              read_sel1,
  output logic [4:0]              read_sel2,
  output logic [ADDRESS_BITS-1:0] out_PC,
  output logic [4:0]              write_sel,
  output logic                    wEn,
  output logic                    branch_op,
  output logic                    next_PC_select,
  output logic [31:0]             imm32,
  output logic [1:0]              op_A_sel,
  output logic                    op_B_sel,
  output logic [5:0]              ALU_Control,
  output logic                    mem_wEn,
  output logic                    wb_sel,
  output logic                    illegal
);

  decode_t                 dec_next;
  decode_t                 slot;
  logic [ADDRESS_BITS-1:0] pc_q;
  logic                    valid_q;
  logic                    hazard;
  logic                    accept;
  logic [6:0]              in_opcode;

  decode_comb #(.ZERO_REG_WEN(ZERO_REG_WEN)) u_decode_comb (
    .instruction (instruction),
    .dec         (dec_next)
  );

  assign in_opcode = instruction[6:0];
  assign read_sel1 = instruction[19:15];
  assign read_sel2 = instruction[24:20];

  // Load-use: a pending load in the slot whose rd feeds the incoming instruction.
  always_comb begin
    hazard = 1'b0;
    if (HAZARD_DETECT && valid_q && slot.wb_sel && (slot.write_sel != 5'd0) && in_valid) begin
      hazard = (uses_rs1(in_opcode) && (instruction[19:15] == slot.write_sel)) ||
               (uses_rs2(in_opcode) && (instruction[24:20] == slot.write_sel));
    end
  end

  assign in_ready = !flush && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Slot register: flush beats accept beats drain; otherwise hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      slot    <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      slot    <= dec_next;
      pc_q    <= PC;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid      = valid_q;
  assign out_PC         = pc_q;
  assign write_sel      = slot.write_sel;
  assign wEn            = slot.wen;
  assign branch_op      = slot.branch_op;
  assign next_PC_select = slot.next_pc_select;
  assign imm32          = slot.imm32;
  assign op_A_sel       = slot.op_a_sel;
  assign op_B_sel       = slot.op_b_sel;
  assign ALU_Control    = slot.alu_control;
  assign mem_wEn        = slot.mem_wen;
  assign wb_sel         = slot.wb_sel;
  assign illegal        = slot.illegal;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Self-checking bench for decode_stage_pipelined: directed scenarios followed
// by randomized traffic, all checked against a behavioural slot model.
module tb_decode_stage_pipelined;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] PC;
  logic [31:0] instruction;
  logic        flush;
  logic        out_valid, out_ready;
  logic [4:0]  read_sel1, read_sel2;
  logic [15:0] out_PC;
  logic [4:0]  write_sel;
  logic        wEn, branch_op, next_PC_select;
  logic [31:0] imm32;
  logic [1:0]  op_A_sel;
  logic        op_B_sel;
  logic [5:0]  ALU_Control;
  logic        mem_wEn, wb_sel, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic        m_valid;
  logic [51:0] m_fields;
  logic [15:0] m_pc;
  logic        last_rdy;

  decode_stage_pipelined #(.ADDRESS_BITS(16), .HAZARD_DETECT(1'b1), .ZERO_REG_WEN(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .PC(PC),
    .instruction(instruction), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .read_sel1(read_sel1), .read_sel2(read_sel2), .out_PC(out_PC), .write_sel(write_sel),
    .wEn(wEn), .branch_op(branch_op), .next_PC_select(next_PC_select), .imm32(imm32),
    .op_A_sel(op_A_sel), .op_B_sel(op_B_sel), .ALU_Control(ALU_Control), .mem_wEn(mem_wEn),
    .wb_sel(wb_sel), .illegal(illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [51:0] dut_fields();
    return {write_sel, wEn, branch_op, next_PC_select, imm32, op_A_sel, op_B_sel,
            ALU_Control, mem_wEn, wb_sel, illegal};
  endfunction

  // Reference decode written straight from the instruction-set rules.
  function automatic logic [51:0] ref_decode(input logic [31:0] i);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we, br, npc, mw, wb, ill, ob;
    logic [1:0]  oa;
    logic [5:0]  alu;
    logic [31:0] imm;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; rd = i[11:7];
    we = 0; br = 0; npc = 0; mw = 0; wb = 0; ill = 0; ob = 0; oa = 2'b00; alu = 6'b0; imm = 0;
    case (op)
      7'h33: begin
        we = 1;
        if (f7 == 7'h20) alu = {3'b001, f3};
        else alu = {3'b000, f3};
        if (f7 != 7'h00 && f7 != 7'h20) ill = 1;
      end
      7'h13: begin
        we = 1; ob = 1; imm = {{20{i[31]}}, i[31:20]};
        alu = {3'b000, f3};
        if (f3 == 3'b001 && f7 != 7'h00) ill = 1;
        if (f3 == 3'b101) begin
          if (f7 == 7'h20) alu = 6'b001101;
          else if (f7 != 7'h00) ill = 1;
        end
      end
      7'h03: begin we = 1; ob = 1; wb = 1; imm = {{20{i[31]}}, i[31:20]}; end
      7'h23: begin mw = 1; ob = 1; imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
      7'h63: begin
        br = 1; npc = 1; alu = {3'b010, f3};
        imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1;
      end
      7'h6F: begin
        we = 1; npc = 1; oa = 2'b10; alu = 6'b011111;
        imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'h67: begin we = 1; npc = 1; oa = 2'b10; alu = 6'b111111; imm = {{20{i[31]}}, i[31:20]}; end
      7'h17: begin we = 1; oa = 2'b01; ob = 1; imm = {i[31:12], 12'b0}; end
      7'h37: begin we = 1; ob = 1; imm = {i[31:12], 12'b0}; end
      default: ill = 1;
    endcase
    if (ill) begin we = 0; mw = 0; end
    if (rd == 5'd0) we = 0;
    return {rd, we, br, npc, imm, oa, ob, alu, mw, wb, ill};
  endfunction

  function automatic logic model_hazard();
    logic [6:0] op;
    logic       r1, r2;
    op = instruction[6:0];
    r1 = (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h67);
    r2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    if (!(m_valid && m_fields[1] && m_fields[51:47] != 5'd0 && in_valid)) return 1'b0;
    return (r1 && instruction[19:15] == m_fields[51:47]) ||
           (r2 && instruction[24:20] == m_fields[51:47]);
  endfunction

  // One clock: check handshake before the edge, advance model, check slot after.
  task automatic cycle();
    logic acc;
    #2;
    last_rdy = !flush && !model_hazard() && (!m_valid || out_ready);
    check("in_ready", in_ready, last_rdy);
    check("read_sel", {read_sel1, read_sel2}, {instruction[19:15], instruction[24:20]});
    acc = in_valid && last_rdy;
    @(posedge clock);
    if (flush) m_valid = 0;
    else if (acc) begin m_valid = 1; m_fields = ref_decode(instruction); m_pc = PC; end
    else if (m_valid && out_ready) m_valid = 0;
    #1;
    check("out_valid", out_valid, m_valid);
    check("slot", {out_PC, dut_fields()}, {m_pc, m_fields});
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, bad;
    int          k;
    w = $urandom; rd = 5'($urandom_range(0, 3)); rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3)); f3 = 3'($urandom);
    bad = 7'($urandom_range(1, 127));
    if (bad == 7'h20) bad = 7'h01;
    k = $urandom_range(0, 3);
    f7 = (k == 0) ? bad : (k == 1 && (f3 == 3'b000 || f3 == 3'b101)) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 10))
      0: return {f7, rs2, rs1, f3, rd, 7'h33};
      1: return {w[31:20], rs1, f3, rd, 7'h13};
      2: begin
        f3 = (w[0]) ? 3'b101 : 3'b001;
        if (f3 == 3'b001 && f7 == 7'h20) f7 = 7'h00;
        return {f7, w[24:20], rs1, f3, rd, 7'h13};
      end
      3: return {w[31:20], rs1, f3, rd, 7'h03};
      4: return {w[31:25], rs2, rs1, f3, w[11:7], 7'h23};
      5: return {w[31:25], rs2, rs1, f3, w[11:7], 7'h63};
      6: return {w[31:12], rd, 7'h6F};
      7: return {w[31:20], rs1, 3'b000, rd, 7'h67};
      8: return {w[31:12], rd, 7'h37};
      9: return {w[31:12], rd, 7'h17};
      default: return w;
    endcase
  endfunction

  initial begin
    reset = 0; in_valid = 0; flush = 0; out_ready = 1; PC = 0; instruction = 0;
    m_valid = 0; m_fields = '0; m_pc = '0; last_rdy = 0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_slot", {out_PC, dut_fields()}, 68'd0);
    reset = 1;

    // addi x1,x0,5
    in_valid = 1; instruction = 32'h00500093; PC = 16'h0100; cycle();
    check("addi_valid", out_valid, 1'b1);
    check("addi_alu", ALU_Control, 6'b000000);
    check("addi_imm", imm32, 32'd5);
    check("addi_opb", op_B_sel, 1'b1);
    check("addi_wen", wEn, 1'b1);
    check("addi_rd", write_sel, 5'd1);

    // load-use: lw x2,0(x1) then add x3,x2,x2
    instruction = 32'h0000A103; PC = 16'h0104; cycle();
    instruction = 32'h002101B3; PC = 16'h0108; cycle();
    check("lu_stall", last_rdy, 1'b0);
    check("lu_in_ready_dut", in_ready, 1'b1);
    check("lu_bubble", out_valid, 1'b0);
    cycle();
    check("lu_add_valid", out_valid, 1'b1);
    check("lu_add_alu", ALU_Control, 6'b000000);
    check("lu_add_rd", write_sel, 5'd3);

    // backpressure
    instruction = 32'h00300113; PC = 16'h010C; cycle();
    out_ready = 0; instruction = 32'h00400193; PC = 16'h0110;
    for (int n = 0; n < 3; n++) begin
      cycle();
      check("bp_ready", last_rdy, 1'b0);
      check("bp_hold", dut_fields(), ref_decode(32'h00300113));
    end
    out_ready = 1; cycle();
    check("bp_accept", last_rdy, 1'b1);
    check("bp_new_imm", imm32, 32'd4);

    // flush with valid slot and pending input
    out_ready = 0; instruction = 32'h00500093; PC = 16'h0114; flush = 1; cycle();
    check("flush_valid", out_valid, 1'b0);
    flush = 0; in_valid = 0; out_ready = 1; cycle();
    check("flush_stale", out_valid, 1'b0);

    // immediates
    in_valid = 1; instruction = 32'hFE000EE3; cycle();
    check("beq_imm", imm32, 32'hFFFFFFFC);
    check("beq_br", branch_op, 1'b1);
    check("beq_alu", ALU_Control, 6'b010000);
    instruction = 32'h800000EF; cycle();
    check("jal_imm", imm32, 32'hFFF00000);
    check("jal_opa", op_A_sel, 2'b10);

    // illegal and x0 destination
    instruction = 32'hFFFFFFFF; cycle();
    check("ill_flag", illegal, 1'b1);
    check("ill_wen", {wEn, mem_wEn}, 2'b00);
    check("ill_valid", out_valid, 1'b1);
    instruction = 32'h00100013; cycle();
    check("x0_wen", wEn, 1'b0);

    // flush during hazard
    instruction = 32'h0000A103; cycle();
    instruction = 32'h002101B3; flush = 1; cycle();
    check("flush_hazard", out_valid, 1'b0);
    flush = 0;

    // reset while stalled on a hazard
    instruction = 32'h0000A103; cycle();
    out_ready = 0; instruction = 32'h002101B3; cycle();
    #3 reset = 0;
    #1;
    m_valid = 0; m_fields = '0; m_pc = '0;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_slot", {out_PC, dut_fields()}, 68'd0);
    check("rst_mid_ready", in_ready, 1'b1);
    #2 reset = 1;
    out_ready = 1; cycle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 15) == 0);
      instruction = gen_instr();
      PC          = 16'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
Registered, handshaked RV32I decode stage. It sits between fetch and execute and holds one decoded instruction in an output slot with valid/ready flow control on both sides. Generalises the combinational decoder with:
- a parametrised address width,
- optional load-use hazard detection with automatic bubble insertion,
- pipeline flush,
- backpressure,
- illegal-instruction flagging.

Parameters:
ADDRESS_BITS, 16, width of PC and out_PC.
HAZARD_DETECT, 1, 1 = insert one bubble on load-use hazard; 0 = never stall for hazards.
ZERO_REG_WEN, 1, 1 = force wEn=0 when rd==x0.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  fetch presents PC/instruction.
in_ready  out  1  stage accepts this cycle.
PC  in  ADDRESS_BITS  PC of incoming instruction.
instruction  in  32  incoming instruction word.
flush  in  1  kill slot contents and refuse input (branch/jump redirect).
out_valid  out  1  slot holds a valid decoded instruction.
out_ready  in  1  execute consumes slot this cycle.
read_sel1  out  5  instruction[19:15], combinational from input, for same-cycle register-file read.
read_sel2  out  5  instruction[24:20], combinational.
out_PC  out  ADDRESS_BITS  registered PC.
write_sel  out  5  registered rd.
wEn  out  1  registered register-file write enable.
branch_op  out  1  registered; 1 for BRANCH.
next_PC_select  out  1  registered; 1 for BRANCH/JAL/JALR.
imm32  out  32  registered sign-extended immediate.
op_A_sel  out  2  registered; 00=rs1, 01=PC, 10=PC+4 path.
op_B_sel  out  1  registered; 0=rs2, 1=imm32.
ALU_Control  out  6  registered ALU operation.
mem_wEn  out  1  registered; 1 for STORE.
wb_sel  out  1  registered; 1 for LOAD.
illegal  out  1  registered; unknown opcode or funct.

Behaviour:
- Reset (reset=0, async): out_valid=0 and every registered output = 0. in_ready stays combinational.
- Latency: 1 cycle. An instruction accepted at edge N is visible on the slot outputs after edge N.
- Acceptance:
  - in_ready = !flush & !hazard & (!out_valid | out_ready).
  - Accept = in_valid & in_ready.
- Slot update at each edge, first match wins:
  1. flush → out_valid=0.
  2. accept → load decoded fields, out_valid=1.
  3. out_valid & out_ready → out_valid=0 (bubble).
  4. Otherwise → hold all fields unchanged.
- Hold rule: while out_valid & !out_ready, every slot output stays bit-stable.
- Hazard (only when HAZARD_DETECT=1): asserted when all of the following hold:
  - out_valid & wb_sel & write_sel!=0;
  - in_valid;
  - the incoming instruction uses rs1==write_sel (R, I, LOAD, STORE, BRANCH, JALR), or uses rs2==write_sel (R, STORE, BRANCH).
- Hazard consequence: the slot drains to a bubble, then the dependent instruction is accepted the following cycle. This gives exactly one bubble when out_ready=1 throughout.
- Immediates:
  - I-type, LOAD, JALR: {20{i[31]}, i[31:20]}.
  - S: {20{i[31]}, i[31:25], i[11:7]}.
  - B: sign-extend {i[31], i[7], i[30:25], i[11:8], 1'b0}.
  - J: sign-extend {i[31], i[19:12], i[20], i[30:21], 1'b0}.
  - U (LUI/AUIPC): {i[31:12], 12'b0}.
- ALU_Control codes:
  - add 000000, sub 001000, sll 000001, slt 000010, sltu 000011, xor 000100.
  - srl 000101, sra 001101, or 000110, and 000111.
  - beq 010000, bne 010001, blt 010100, bge 010101, bltu 010110, bgeu 010111.
  - JAL 011111, JALR 111111.
  - LOAD, STORE, LUI, AUIPC use add.
- sub/sra/srai are selected by funct7==0100000. For R-type, any other funct7 not equal to 0000000 sets illegal.
- Per-opcode control:
  - LUI: op_A_sel=00, treated as x0+imm (read_sel1 is ignored by execute).
  - AUIPC: op_A_sel=01, next_PC_select=0.
  - JAL/JALR: op_A_sel=10, wEn=1.
- illegal=1 cases: unknown opcode, branch funct3 010/011, or bad funct7. When illegal=1, wEn=0 and mem_wEn=0; the slot is still valid so a downstream trap can observe it.
- ZERO_REG_WEN=1: wEn=0 whenever write_sel==0.
- Simultaneous flush & hazard: flush wins. Reset mid-stall: slot cleared immediately.

Decomposition:
- Package decode_pkg: opcode localparams (R_TYPE, I_TYPE, STORE, LOAD, BRANCH, JALR, JAL, AUIPC, LUI), ALU_Control codes, op_A_sel encodings.
- Sub-module decode_comb: pure combinational instruction → control/immediate/illegal decoder.
- Top level owns the slot register, the handshake, and the hazard logic.

Test Plan:
- Reset: after reset, out_valid=0 and in_ready=1. Then 0x00500093 (addi x1,x0,5) → next cycle out_valid=1, ALU_Control=000000, imm32=5, op_B_sel=1, wEn=1, write_sel=1.
- Load-use: 0x0000A103 (lw x2,0(x1)) then 0x002101B3 (add x3,x2,x2), out_ready=1 → in_ready=0 for one cycle, exactly one out_valid=0 cycle, then the add appears with ALU_Control=000000.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and slot outputs bit-stable. Raise out_ready → next instruction accepted on that edge.
- Flush: assert flush with a valid slot and in_valid=1 → out_valid=0 next cycle, input not consumed, no stale decode afterwards.
- Immediates: 0xFE000EE3 (beq x0,x0,-4) → imm32=0xFFFFFFFC, branch_op=1, ALU_Control=010000. 0x800000EF (jal) → imm32=0xFFF00000.
- Illegal / x0: 0xFFFFFFFF → illegal=1, wEn=0, mem_wEn=0. 0x00100013 (addi x0,x0,1) → wEn=0.
